ls_block_arbiter: RTL and testbench
===================================

# ls_block_arbiter

Block-granular round-robin arbiter that shares the single 8-lane level-shift / int-to-float row datapath between the Y, Cb and Cr block producers. It grants one requester for a whole 8-row block, registers each accepted pixel row into the datapath, and carries a component/row tag through a delay line matched to the datapath latency. The tag comes out aligned with the datapath's result valid. It sits between the colour-conversion/downsampling stage and the DCT input buffer.

## Interface
- `N_REQ`, 3, number of requesters (0 = Y, 1 = Cb, 2 = Cr)
- `ROWS`, 8, rows per block
- `LS_LAT`, 2, cycles from `ls_din_valid` to `ls_dout_valid` in the shared datapath
- `clk`  in  1  single clock, rising edge
- `nrst`  in  1  asynchronous active-low reset
- `req_valid`  in  N_REQ  requester r has a row available
- `req_data`  in  N_REQ×8×8  per-requester row, 8 unsigned 8-bit pixels
- `req_ready`  out  N_REQ  row of requester r accepted this cycle when `req_valid[r]` is also high
- `ls_din`  out  8×8  registered row driven into the level-shift datapath
- `ls_din_valid`  out  1  `ls_din` valid
- `ls_dout_valid`  in  1  datapath result valid
- `tag_valid`  out  1  tag valid, equal to `ls_dout_valid` when the pipe is consistent
- `tag_comp`  out  2  component of the current result row
- `tag_row`  out  3  row index 0..7 within the block
- `tag_last`  out  1  result row is row 7 of its block
- `busy`  out  1  FSM not IDLE, or any tag in flight
- `err`  out  1  sticky; set if `ls_dout_valid` disagrees with the tag pipe valid bit

## Operation
- FSM states:
  - IDLE: `rr_ptr` selects the first requester with `req_valid` high, scanning rr_ptr, rr_ptr+1, … mod N_REQ. On a hit, latch `grant` and go to BURST. If none is valid, stay in IDLE.
  - BURST: `req_ready[grant]=1` and all other `req_ready` bits are 0. Each handshake loads `ls_din`, pulses `ls_din_valid`, pushes tag {grant, row_cnt, row_cnt==7} and increments `row_cnt`.
  - BURST exit: on the handshake with `row_cnt==7`, set `row_cnt←0`, `rr_ptr←(grant+1) mod N_REQ`, and return to IDLE.
- No preemption. If `req_valid[grant]` drops mid-block, BURST stalls with the grant held, and no rows from other requesters are accepted.
- `req_ready` is never asserted in IDLE, so there is exactly one bubble cycle between blocks.
- Tag pipe: LS_LAT+1 stage shift register of {valid, comp, row, last}, advancing every cycle. Its output drives the `tag_*` ports.
- `err` sets when the pipe output valid ≠ `ls_dout_valid`. It clears only on reset.
- `ls_din` holds its last value when `ls_din_valid` is 0.
- Reset (asynchronous, any time, including mid-block):
  - FSM→IDLE; `rr_ptr`, `grant`, `row_cnt`=0
  - tag pipe cleared
  - all outputs 0 (`ls_din` all zero, `req_ready`=0, `busy`=0, `err`=0)
  - A partially sent block is discarded; the producer restarts it.

## Timing
- A handshake at edge t gives `ls_din` / `ls_din_valid` at t+1 and the tag at t+1+LS_LAT, coincident with `ls_dout_valid`.
- `req_ready` is a registered state decode plus the `grant` compare. It does not depend combinationally on `req_valid`.
- First grant: `req_valid` high at cycle c in IDLE → BURST at c+1 → first handshake at c+1.
- Full-rate block: 8 consecutive rows. The next block's first row comes at the earliest 2 cycles after row 7 (one IDLE bubble).
- Throughput: 8 rows per 9 cycles per block with continuous requests.

## Structure
- Shared package `jpeg_pkg`:
  - `comp_t` enum {COMP_Y, COMP_CB, COMP_CR}
  - `ls_tag_t` packed struct {valid, comp, row, last}
  - constant `ROWS_PER_BLK=8`
- One sub-module `ls_tag_pipe`: parameterised-depth delay line of `ls_tag_t`, with async reset clearing all stages.
- The arbiter FSM, round-robin selection and row counter live in the top module.

## Test plan
- **Single requester:** only Y is valid, with 8 rows of constant 0x80. Expect `ls_din_valid` for 8 consecutive cycles and `tag_comp=0`, `tag_row` 0..7, `tag_last` only on row 7. `err`=0.
- **All three always valid:** blocks granted in order Y, Cb, Cr, Y. Exactly one idle cycle between blocks. 24 rows in 27 cycles.
- **Mid-block stall:** Cb drops `req_valid` after row 3 for 5 cycles while Y and Cr are valid. Grant stays on Cb, no Y/Cr rows are accepted, and Cb resumes at `tag_row`=4.
- **Reset at row 5 of a Cr block:** all outputs 0 immediately. After release, `rr_ptr`=0 and Y is granted first; no stale tags appear.
- **Latency mismatch:** model `ls_dout_valid` one cycle late. `err` sets on the first row and stays set.
- **Data path:** `req_data` row = {0x00, 0xFF, 0x7F, 0x80, 0x01, 0xFE, 0x40, 0xC0}. `ls_din` equals it exactly one cycle after the handshake.

Source files
------------

// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared JPEG pipeline types: component enum, level-shift tag, block geometry
package jpeg_pkg;

  localparam int ROWS_PER_BLK = 8;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_t;

  typedef struct packed {
    logic       valid;
    comp_t      comp;
    logic [2:0] row;
    logic       last;
  } ls_tag_t;

endpackage

// File: rtl/ls_tag_pipe.sv
// rtl/ls_tag_pipe.sv - fixed-depth delay line carrying row tags alongside the level-shift datapath
module ls_tag_pipe
  import jpeg_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic    clk,
  input  logic    nrst,
  input  ls_tag_t tag_i,
  output ls_tag_t tag_o,
  output logic    any_valid_o
);

  ls_tag_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  always_comb begin
    any_valid_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid_o = any_valid_o | stage_q[i].valid;
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ls_block_arbiter.sv
// rtl/ls_block_arbiter.sv - block-granular round-robin arbiter feeding the shared level-shift row datapath
module ls_block_arbiter
  import jpeg_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ROWS   = ROWS_PER_BLK,
  parameter int LS_LAT = 2
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][7:0][7:0]  req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic [7:0][7:0]             ls_din,
  output logic                        ls_din_valid,
  input  logic                        ls_dout_valid,
  output logic                        tag_valid,
  output logic [1:0]                  tag_comp,
  output logic [2:0]                  tag_row,
  output logic                        tag_last,
  output logic                        busy,
  output logic                        err
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          state_q, state_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [1:0]      grant_q, grant_d;
  logic [2:0]      row_cnt_q, row_cnt_d;
  logic [7:0][7:0] ls_din_q, ls_din_d;
  logic            din_valid_q, din_valid_d;
  logic            err_q, err_d;
  logic            hit, hs, pipe_busy;
  logic [1:0]      sel, idx_b;
  int              idx;
  ls_tag_t         tag_in, tag_out;

  // Round-robin scan starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    hit   = 1'b0;
    sel   = rr_ptr_q;
    idx   = 0;
    idx_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_b = 2'(idx);
      if (!hit && req_valid[idx_b]) begin
        hit = 1'b1;
        sel = idx_b;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_BURST) req_ready[grant_q] = 1'b1;
  end

  assign hs = (state_q == S_BURST) && req_valid[grant_q];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    row_cnt_d   = row_cnt_q;
    ls_din_d    = ls_din_q;
    din_valid_d = 1'b0;
    tag_in      = '0;
    err_d       = err_q | (tag_out.valid ^ ls_dout_valid);
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          grant_d = sel;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        // No preemption: a stalled grantee simply holds the datapath.
        if (hs) begin
          ls_din_d    = req_data[grant_q];
          din_valid_d = 1'b1;
          tag_in      = '{valid: 1'b1, comp: comp_t'(grant_q), row: row_cnt_q,
                          last: (row_cnt_q == 3'(ROWS-1))};
          if (row_cnt_q == 3'(ROWS-1)) begin
            row_cnt_d = '0;
            rr_ptr_d  = (grant_q == 2'(N_REQ-1)) ? 2'd0 : grant_q + 2'd1;
            state_d   = S_IDLE;
          end else begin
            row_cnt_d = row_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      row_cnt_q   <= '0;
      ls_din_q    <= '0;
      din_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      row_cnt_q   <= row_cnt_d;
      ls_din_q    <= ls_din_d;
      din_valid_q <= din_valid_d;
      err_q       <= err_d;
    end
  end

  // One stage for the ls_din register plus LS_LAT for the datapath itself.
  ls_tag_pipe #(.DEPTH(LS_LAT + 1)) u_tag_pipe (
    .clk         (clk),
    .nrst        (nrst),
    .tag_i       (tag_in),
    .tag_o       (tag_out),
    .any_valid_o (pipe_busy)
  );

  assign ls_din       = ls_din_q;
  assign ls_din_valid = din_valid_q;
  assign tag_valid    = tag_out.valid;
  assign tag_comp     = tag_out.comp;
  assign tag_row      = tag_out.row;
  assign tag_last     = tag_out.last;
  assign busy         = (state_q != S_IDLE) || pipe_busy;
  assign err          = err_q;

endmodule

// File: tb/tb_ls_block_arbiter.sv
// tb/tb_ls_block_arbiter.sv - scoreboard bench for ls_block_arbiter
module tb_ls_block_arbiter;
  import jpeg_pkg::*;

  localparam int N_REQ  = 3;
  localparam int LS_LAT = 2;

  logic                       clk = 1'b0;
  logic                       nrst = 1'b0;
  logic [N_REQ-1:0]           req_valid = '0;
  logic [N_REQ-1:0][7:0][7:0] req_data;
  logic [N_REQ-1:0]           req_ready;
  logic [7:0][7:0]            ls_din;
  logic                       ls_din_valid, ls_dout_valid, tag_valid, tag_last, busy, err;
  logic [1:0]                 tag_comp;
  logic [2:0]                 tag_row;

  int          errors = 0;
  int          checks = 0;
  logic        use_fixed = 1'b0;
  logic [63:0] fixed_row = '0;
  logic        late = 1'b0;
  logic [2:0]  prod_row [N_REQ];
  logic [LS_LAT:0] dly;

  typedef struct {
    logic [1:0]  comp;
    logic [2:0]  row;
    logic        last;
    logic [63:0] data;
  } exp_t;
  exp_t din_q[$];
  exp_t tag_q[$];

  ls_block_arbiter #(.N_REQ(N_REQ), .ROWS(8), .LS_LAT(LS_LAT)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .ls_din        (ls_din),
    .ls_din_valid  (ls_din_valid),
    .ls_dout_valid (ls_dout_valid),
    .tag_valid     (tag_valid),
    .tag_comp      (tag_comp),
    .tag_row       (tag_row),
    .tag_last      (tag_last),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pix(input int c, input logic [2:0] row);
    logic [63:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) p[k*8 +: 8] = 8'(c*64 + int'(row)*8 + k);
    return p;
  endfunction

  // Producers step their row on each accepted handshake; datapath model delays ls_din_valid.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int r = 0; r < N_REQ; r++) prod_row[r] <= '0;
      dly <= '0;
    end else begin
      for (int r = 0; r < N_REQ; r++)
        if (req_valid[r] && req_ready[r]) prod_row[r] <= prod_row[r] + 3'd1;
      dly <= {dly[LS_LAT-1:0], ls_din_valid};
    end
  end

  assign ls_dout_valid = late ? dly[LS_LAT] : dly[LS_LAT-1];

  always_comb begin
    for (int r = 0; r < N_REQ; r++)
      req_data[r] = use_fixed ? fixed_row : pix(r, prod_row[r]);
  end

  task automatic push_block(input int c);
    exp_t e;
    for (int row = 0; row < 8; row++) begin
      e.comp = 2'(c);
      e.row  = 3'(row);
      e.last = (row == 7);
      e.data = use_fixed ? fixed_row : pix(c, 3'(row));
      din_q.push_back(e);
      tag_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (nrst && ls_din_valid) begin
      checks++;
      if (din_q.size() == 0) begin
        errors++;
        $display("FAIL din_unexpected: got ls_din=%h, expected no row", ls_din);
      end else begin
        e = din_q.pop_front();
        if (ls_din !== e.data) begin
          errors++;
          $display("FAIL ls_din: got %h expected %h", ls_din, e.data);
        end
      end
    end
    if (nrst && tag_valid) begin
      checks++;
      if (tag_q.size() == 0) begin
        errors++;
        $display("FAIL tag_unexpected: got comp=%0d row=%0d, expected no tag", tag_comp, tag_row);
      end else begin
        e = tag_q.pop_front();
        if ({tag_comp, tag_row, tag_last} !== {e.comp, e.row, e.last}) begin
          errors++;
          $display("FAIL tag: got comp=%0d row=%0d last=%0d expected comp=%0d row=%0d last=%0d",
                   tag_comp, tag_row, tag_last, e.comp, e.row, e.last);
        end
      end
    end
  end

  task automatic test_reset();
    nrst = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if ({req_ready, ls_din, ls_din_valid, tag_valid, tag_comp, tag_row, tag_last, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b din=%h busy=%b err=%b expected all zero",
               req_ready, ls_din, busy, err);
    end
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b err=%b expected 0", req_ready, busy, err);
    end
  endtask

  task automatic test_all_three();
    logic exp_v;
    push_block(0); push_block(1); push_block(2); push_block(0);
    req_valid = 3'b111;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      exp_v = (i % 9) != 0;
      checks++;
      if (ls_din_valid !== exp_v) begin
        errors++;
        $display("FAIL all_three_cadence[%0d]: got din_valid=%b expected %b", i, ls_din_valid, exp_v);
      end
      if (i == 35) req_valid = '0;
    end
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || din_q.size() != 0 || tag_q.size() != 0) begin
      errors++;
      $display("FAIL all_three_drain: got busy=%b err=%b din_left=%0d tag_left=%0d expected 0",
               busy, err, din_q.size(), tag_q.size());
    end
  endtask

  task automatic test_stall();
    push_block(1); push_block(2); push_block(0);
    req_valid = 3'b111;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i >= 5 && i <= 9) begin
        checks++;
        if (req_ready !== 3'b010 || ls_din_valid !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold[%0d]: got ready=%b din_valid=%b expected 010/0", i, req_ready, ls_din_valid);
        end
      end
      if (i == 4)  req_valid = 3'b101;
      if (i == 9)  req_valid = 3'b111;
      if (i == 31) req_valid = '0;
    end
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || din_q.size() != 0 || tag_q.size() != 0) begin
      errors++;
      $display("FAIL stall_drain: got busy=%b err=%b din_left=%0d tag_left=%0d expected 0",
               busy, err, din_q.size(), tag_q.size());
    end
  endtask

  task automatic test_single();
    logic exp_v;
    use_fixed = 1'b1;
    fixed_row = 64'h8080808080808080;
    push_block(0);
    req_valid = 3'b001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_v = (i >= 1 && i <= 8);
      checks++;
      if (ls_din_valid !== exp_v) begin
        errors++;
        $display("FAIL single_valid[%0d]: got %b expected %b", i, ls_din_valid, exp_v);
      end
      if (i == 8) req_valid = '0;
    end
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || din_q.size() != 0 || tag_q.size() != 0) begin
      errors++;
      $display("FAIL single_drain: got busy=%b err=%b din_left=%0d tag_left=%0d expected 0",
               busy, err, din_q.size(), tag_q.size());
    end
  endtask

  task automatic test_datapath();
    logic [63:0] prev;
    prev = fixed_row;
    fixed_row = 64'h00FF7F8001FE40C0;
    push_block(0);
    req_valid = 3'b001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (ls_din !== prev) begin
          errors++;
          $display("FAIL datapath_hold_before: got %h expected %h", ls_din, prev);
        end
      end
      if (i == 1 || i == 9) begin
        checks++;
        if (ls_din !== 64'h00FF7F8001FE40C0) begin
          errors++;
          $display("FAIL datapath_row[%0d]: got %h expected 00ff7f8001fe40c0", i, ls_din);
        end
      end
      if (i == 8) req_valid = '0;
    end
    repeat (8) @(negedge clk);
    use_fixed = 1'b0;
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || din_q.size() != 0 || tag_q.size() != 0) begin
      errors++;
      $display("FAIL datapath_drain: got busy=%b err=%b din_left=%0d tag_left=%0d expected 0",
               busy, err, din_q.size(), tag_q.size());
    end
  endtask

  task automatic test_reset_mid_block();
    exp_t e;
    for (int row = 0; row < 5; row++) begin
      e.comp = 2'd2; e.row = 3'(row); e.last = 1'b0; e.data = pix(2, 3'(row));
      din_q.push_back(e);
      if (row < 3) tag_q.push_back(e);
    end
    req_valid = 3'b100;
    for (int i = 0; i < 6; i++) @(negedge clk);
    #2;
    nrst = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if ({req_ready, ls_din, ls_din_valid, tag_valid, tag_comp, tag_row, tag_last, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got ready=%b din=%h dv=%b tv=%b busy=%b expected all zero",
               req_ready, ls_din, ls_din_valid, tag_valid, busy);
    end
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    push_block(0);
    req_valid = 3'b111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (req_ready !== 3'b001) begin
          errors++;
          $display("FAIL reset_mid_first_grant: got ready=%b expected 001", req_ready);
        end
      end
      if (i == 8) req_valid = '0;
    end
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || din_q.size() != 0 || tag_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_drain: got busy=%b err=%b din_left=%0d tag_left=%0d expected 0",
               busy, err, din_q.size(), tag_q.size());
    end
  endtask

  task automatic test_latency_mismatch();
    bit seen;
    int first;
    seen = 1'b0;
    first = 0;
    late = 1'b1;
    push_block(0);
    req_valid = 3'b001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 8) req_valid = '0;
      if (seen && i == first + 1) begin
        checks++;
        if (err !== 1'b1) begin
          errors++;
          $display("FAIL mismatch_err_set: got err=%b expected 1", err);
        end
      end
      if (tag_valid && !seen) begin
        seen = 1'b1;
        first = i;
        checks++;
        if (err !== 1'b0) begin
          errors++;
          $display("FAIL mismatch_err_early: got err=%b expected 0", err);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mismatch_timeout: got no tag_valid within 20 cycles, expected one");
    end
    repeat (8) @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_sticky: got err=%b busy=%b expected 1/0", err, busy);
    end
    late = 1'b0;
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_reset_clear: got err=%b expected 0", err);
    end
  endtask

  initial begin
    test_reset();
    test_all_three();
    test_stall();
    test_single();
    test_datapath();
    test_reset_mid_block();
    test_latency_mismatch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
